// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: decode op encoding and
// default reset/exception addresses.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_BR   = 3'd1,
    OP_J    = 3'd2,
    OP_JAL  = 3'd3,
    OP_JR   = 3'd4
  } id_op_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

  localparam int MISS_CNT_W = 16;

  // Sign-extend a 16-bit branch immediate and scale it to a byte offset.
  function automatic logic [31:0] br_byte_offset(input logic [15:0] imm);
    br_byte_offset = {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push onto a full stack overwrites the
// oldest entry, a pop of an empty stack is ignored.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [XLEN-1:0]              i_push_data,
  input  logic                         i_pop,
  output logic [XLEN-1:0]              o_top,
  output logic [$clog2(RAS_DEPTH):0]   o_count,
  output logic                         o_empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_top_idx;

  // r_ptr names the next free slot, so the top sits one below it.
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      r_mem[r_ptr] <= i_push_data;
      r_ptr        <= r_ptr + PTR_W'(1);
      if (r_count != FULL_COUNT) begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (i_pop && (r_count != '0)) begin
      r_ptr   <= r_ptr - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: exception/redirect selection with stall-time pending
// redirect capture, plus return-address-stack misprediction statistics.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(DEFAULT_EXC_VECTOR),
  parameter int              RAS_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_stall,
  input  logic                        i_exc_req,
  input  logic                        i_id_valid,
  input  logic [2:0]                  i_id_op,
  input  logic                        i_br_taken,
  input  logic [XLEN-1:0]             i_id_pc4,
  input  logic [15:0]                 i_br_offset,
  input  logic [25:0]                 i_j_index,
  input  logic [XLEN-1:0]             i_jr_target,
  input  logic                        i_jr_is_ra,
  output logic [XLEN-1:0]             o_pc,
  output logic [XLEN-1:0]             o_pc4,
  output logic [XLEN-1:0]             o_link_addr,
  output logic [$clog2(RAS_DEPTH):0]  o_ras_count,
  output logic                        o_ras_miss,
  output logic [MISS_CNT_W-1:0]       o_miss_cnt
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [XLEN-1:0]       r_pc;
  logic                  r_pend_valid;
  logic [XLEN-1:0]       r_pend_target;
  logic                  r_ras_miss;
  logic [MISS_CNT_W-1:0] r_miss_cnt;

  logic [XLEN-1:0]  w_pc4;
  logic [XLEN-1:0]  w_br_target;
  logic [XLEN-1:0]  w_j_target;
  logic [XLEN-1:0]  w_target;
  logic             w_redirect;
  logic             w_accepted;
  logic             w_push;
  logic             w_pop;
  logic             w_miss;
  logic [XLEN-1:0]  w_ras_top;
  logic [CNT_W-1:0] w_ras_count;
  logic             w_ras_empty;

  assign w_pc4       = r_pc + XLEN'(4);
  assign w_br_target = i_id_pc4 + XLEN'($signed(br_byte_offset(i_br_offset)));
  assign w_j_target  = {i_id_pc4[XLEN-1:28], i_j_index, 2'b00};

  // Unused op codes (5-7) fall to the default arm and never redirect.
  always_comb begin
    w_target   = '0;
    w_redirect = 1'b0;
    case (i_id_op)
      OP_BR: begin
        w_target   = w_br_target;
        w_redirect = i_br_taken;
      end
      OP_J, OP_JAL: begin
        w_target   = w_j_target;
        w_redirect = 1'b1;
      end
      OP_JR: begin
        w_target   = i_jr_target;
        w_redirect = 1'b1;
      end
      default: begin
        w_target   = '0;
        w_redirect = 1'b0;
      end
    endcase
    w_redirect = w_redirect & i_id_valid;
  end

  // A redirect seen while stalled is parked and wins over the live redirect
  // on the first unstalled cycle; an exception discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else if (i_exc_req) begin
      r_pc         <= EXC_VECTOR;
      r_pend_valid <= 1'b0;
    end else if (i_stall) begin
      if (w_redirect) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_target;
      end
    end else if (r_pend_valid) begin
      r_pc         <= r_pend_target;
      r_pend_valid <= 1'b0;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else begin
      r_pc <= w_pc4;
    end
  end

  assign w_accepted  = i_id_valid & ~i_stall & ~i_exc_req;
  assign w_push      = w_accepted & (i_id_op == OP_JAL);
  assign w_pop       = w_accepted & (i_id_op == OP_JR) & i_jr_is_ra;
  assign o_link_addr = i_id_pc4 + XLEN'(4);

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (o_link_addr),
    .i_pop       (w_pop),
    .o_top       (w_ras_top),
    .o_count     (w_ras_count),
    .o_empty     (w_ras_empty)
  );

  assign w_miss = w_pop & (w_ras_empty | (w_ras_top != i_jr_target));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ras_miss <= 1'b0;
      r_miss_cnt <= '0;
    end else begin
      r_ras_miss <= w_miss;
      if (w_miss && (r_miss_cnt != {MISS_CNT_W{1'b1}})) begin
        r_miss_cnt <= r_miss_cnt + MISS_CNT_W'(1);
      end
    end
  end

  assign o_pc        = r_pc;
  assign o_pc4       = w_pc4;
  assign o_ras_count = w_ras_count;
  assign o_ras_miss  = r_ras_miss;
  assign o_miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a queue-based reference model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam int XLEN      = 32;
  localparam int RAS_DEPTH = 4;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        stall    = 1'b0;
  logic        excReq   = 1'b0;
  logic        idValid  = 1'b0;
  logic [2:0]  idOp     = 3'd0;
  logic        brTaken  = 1'b0;
  logic [31:0] idPc4    = 32'd0;
  logic [15:0] brOffset = 16'd0;
  logic [25:0] jIndex   = 26'd0;
  logic [31:0] jrTarget = 32'd0;
  logic        jrIsRa   = 1'b0;

  logic [31:0] oPc, oPc4, oLinkAddr;
  logic [2:0]  oRasCount;
  logic        oRasMiss;
  logic [15:0] oMissCnt;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  pc_gen #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_stall     (stall),
    .i_exc_req   (excReq),
    .i_id_valid  (idValid),
    .i_id_op     (idOp),
    .i_br_taken  (brTaken),
    .i_id_pc4    (idPc4),
    .i_br_offset (brOffset),
    .i_j_index   (jIndex),
    .i_jr_target (jrTarget),
    .i_jr_is_ra  (jrIsRa),
    .o_pc        (oPc),
    .o_pc4       (oPc4),
    .o_link_addr (oLinkAddr),
    .o_ras_count (oRasCount),
    .o_ras_miss  (oRasMiss),
    .o_miss_cnt  (oMissCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: fetch address rules and a RAS held as a plain queue
  logic [31:0] mPc;
  bit          mPendV;
  logic [31:0] mPendT;
  logic [31:0] mRas[$];
  bit          mMiss;
  int          mMissCnt;

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] tgt;
    logic [31:0] popped;
    bit          redir;
    bit          acc;
    if (!rst_n) begin
      mPc      = 32'h0000_3000;
      mPendV   = 1'b0;
      mPendT   = 32'd0;
      mRas.delete();
      mMiss    = 1'b0;
      mMissCnt = 0;
    end else begin
      tgt   = 32'd0;
      redir = 1'b0;
      if (idValid) begin
        if (idOp == 3'd1 && brTaken) begin
          redir = 1'b1;
          tgt   = idPc4 + ({{16{brOffset[15]}}, brOffset} * 4);
        end else if (idOp == 3'd2 || idOp == 3'd3) begin
          redir = 1'b1;
          tgt   = (idPc4 & 32'hF000_0000) | ({6'd0, jIndex} * 4);
        end else if (idOp == 3'd4) begin
          redir = 1'b1;
          tgt   = jrTarget;
        end
      end
      acc   = idValid && !stall && !excReq;
      mMiss = 1'b0;
      if (acc && idOp == 3'd3) begin
        mRas.push_back(idPc4 + 32'd4);
        if (mRas.size() > RAS_DEPTH) void'(mRas.pop_front());
      end
      if (acc && idOp == 3'd4 && jrIsRa) begin
        if (mRas.size() == 0) mMiss = 1'b1;
        else begin
          popped = mRas.pop_back();
          mMiss  = (popped != jrTarget);
        end
      end
      if (mMiss && mMissCnt < 65535) mMissCnt++;
      if (excReq) begin
        mPc    = 32'h0000_4180;
        mPendV = 1'b0;
      end else if (stall) begin
        if (redir) begin
          mPendV = 1'b1;
          mPendT = tgt;
        end
      end else if (mPendV) begin
        mPc    = mPendT;
        mPendV = 1'b0;
      end else if (redir) begin
        mPc = tgt;
      end else begin
        mPc = mPc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("pc", oPc, mPc);
      checkOutput("pc4", oPc4, mPc + 32'd4);
      checkOutput("link_addr", oLinkAddr, idPc4 + 32'd4);
      checkOutput("ras_count", 32'(oRasCount), 32'(mRas.size()));
      checkOutput("ras_miss", 32'(oRasMiss), 32'(mMiss));
      checkOutput("miss_cnt", 32'(oMissCnt), 32'(mMissCnt));
    end
  end

  task automatic applyStimulus(input logic st, input logic exc, input logic vld,
                               input logic [2:0] op, input logic tk,
                               input logic [31:0] pc4In, input logic [15:0] off,
                               input logic [25:0] idx, input logic [31:0] jrT,
                               input logic isRa);
    stall    = st;
    excReq   = exc;
    idValid  = vld;
    idOp     = op;
    brTaken  = tk;
    idPc4    = pc4In;
    brOffset = off;
    jIndex   = idx;
    jrTarget = jrT;
    jrIsRa   = isRa;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 3'd0, 0, 32'd0, 16'd0, 26'd0, 32'd0, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    checkEn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset pc", oPc, 32'h0000_3000);
    checkOutput("reset ras_count", 32'(oRasCount), 32'd0);
    rst_n = 1'b1;

    idle(); checkOutput("seq pc 1", oPc, 32'h0000_3004);
    idle(); checkOutput("seq pc 2", oPc, 32'h0000_3008);
    idle(); checkOutput("seq pc 3", oPc, 32'h0000_300C);
    checkOutput("pc4 comb", oPc4, 32'h0000_3010);

    applyStimulus(0, 0, 1, 3'd1, 1, 32'h3010, 16'hFFFC, 26'd0, 32'd0, 0);
    checkOutput("br taken", oPc, 32'h0000_3000);
    checkOutput("link comb", oLinkAddr, 32'h0000_3014);
    applyStimulus(0, 0, 1, 3'd1, 0, 32'h3010, 16'hFFFC, 26'd0, 32'd0, 0);
    checkOutput("br not taken", oPc, 32'h0000_3004);
    applyStimulus(0, 0, 1, 3'd2, 0, 32'h3010, 16'd0, 26'h000_0C40, 32'd0, 0);
    checkOutput("j target", oPc, 32'h0000_3100);
    applyStimulus(0, 0, 1, 3'd1, 1, 32'h3100, 16'h0010, 26'd0, 32'd0, 0);
    checkOutput("br fwd", oPc, 32'h0000_3140);
    applyStimulus(0, 0, 1, 3'd5, 1, 32'h3100, 16'h0010, 26'h3FF_FFFF, 32'h5000, 0);
    checkOutput("op5 as none", oPc, 32'h0000_3144);

    applyStimulus(1, 0, 1, 3'd4, 0, 32'h3100, 16'd0, 26'd0, 32'h3200, 0);
    checkOutput("stall hold 1", oPc, 32'h0000_3144);
    applyStimulus(1, 0, 1, 3'd4, 0, 32'h3100, 16'd0, 26'd0, 32'h3400, 0);
    checkOutput("stall hold 2", oPc, 32'h0000_3144);
    applyStimulus(1, 0, 0, 3'd0, 0, 32'h0, 16'd0, 26'd0, 32'h0, 0);
    checkOutput("stall hold 3", oPc, 32'h0000_3144);
    idle(); checkOutput("pending load", oPc, 32'h0000_3400);
    idle(); checkOutput("after pending", oPc, 32'h0000_3404);

    applyStimulus(1, 0, 1, 3'd4, 0, 32'h3100, 16'd0, 26'd0, 32'h3500, 0);
    applyStimulus(1, 1, 0, 3'd0, 0, 32'h0, 16'd0, 26'd0, 32'h0, 0);
    checkOutput("exc in stall", oPc, 32'h0000_4180);
    idle(); checkOutput("pending cleared", oPc, 32'h0000_4184);
    applyStimulus(0, 1, 1, 3'd4, 0, 32'h3100, 16'd0, 26'd0, 32'h3600, 0);
    checkOutput("exc over redirect", oPc, 32'h0000_4180);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 3'd3, 0, 32'h3004 + 32'(4 * i), 16'd0, 26'h000_0C00, 32'd0, 0);
    end
    checkOutput("ras full count", 32'(oRasCount), 32'd4);
    applyStimulus(1, 0, 1, 3'd3, 0, 32'h3050, 16'd0, 26'h000_0C00, 32'd0, 0);
    idle();
    checkOutput("stalled jal no push", 32'(oRasCount), 32'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 3'd4, 0, 32'h3000, 16'd0, 26'd0, 32'h3018 - 32'(4 * i), 1);
      checkOutput("clean pop miss", 32'(oRasMiss), 32'd0);
    end
    checkOutput("ras drained", 32'(oRasCount), 32'd0);
    applyStimulus(0, 0, 1, 3'd4, 0, 32'h3000, 16'd0, 26'd0, 32'h3008, 1);
    checkOutput("empty pop miss", 32'(oRasMiss), 32'd1);
    checkOutput("empty pop cnt", 32'(oMissCnt), 32'd1);
    checkOutput("empty pop pc", oPc, 32'h0000_3008);
    checkOutput("empty pop count", 32'(oRasCount), 32'd0);
    idle(); checkOutput("miss one cycle", 32'(oRasMiss), 32'd0);

    applyStimulus(0, 0, 1, 3'd3, 0, 32'h3004, 16'd0, 26'h000_0C00, 32'd0, 0);
    applyStimulus(0, 0, 1, 3'd4, 0, 32'h3000, 16'd0, 26'd0, 32'h3100, 0);
    checkOutput("jr non-ra keeps ras", 32'(oRasCount), 32'd1);
    applyStimulus(0, 0, 1, 3'd4, 0, 32'h3000, 16'd0, 26'd0, 32'h3100, 1);
    checkOutput("wrong ret miss", 32'(oRasMiss), 32'd1);
    checkOutput("wrong ret pc", oPc, 32'h0000_3100);
    checkOutput("wrong ret cnt", 32'(oMissCnt), 32'd2);
    idle(); checkOutput("wrong ret pulse end", 32'(oRasMiss), 32'd0);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset pc", oPc, 32'h0000_3000);
    checkOutput("async reset cnt", 32'(oMissCnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(); checkOutput("post reset pc", oPc, 32'h0000_3004);
    idle();

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
